// File: rtl/seq_alu_if.sv
// Bus bundle for seq_alu: request side (start/op/a/b) and completion side
// (busy/valid/result/hi/flags). The master drives requests, the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, valid, result, hi, zero, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, valid, result, hi, zero, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU. Legacy logic/arith ops finish in one cycle;
// MULT/MULTU/DIV/DIVU iterate one bit per cycle (shift-add multiply,
// restoring divide on magnitudes), then a FIX cycle applies sign correction.
module seq_alu #(
    parameter int WIDTH      = 32,
    parameter int DIV_ENABLE = 1
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_ANDN  = 4'b0100;
    localparam logic [3:0] OP_ORN   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + WIDTH'(1);
    endfunction

    // Absolute value for signed ops; MIN maps to 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;       // product high / partial remainder
    logic [WIDTH-1:0] q_r;         // multiplier (shifted out) / quotient (shifted in)
    logic [WIDTH-1:0] opb_r;       // multiplicand / divisor magnitude
    logic             mode_div_r;
    logic             neg_q_r;     // negate product or quotient in FIX
    logic             neg_r_r;     // negate remainder in FIX

    logic             busy_r;
    logic             valid_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             zero_r;
    logic             dbz_r;

    logic             is_mul_s;
    logic             is_div_s;
    logic             is_signed_s;
    logic             b_zero_s;
    logic             launch_s;
    logic             single_s;
    logic [WIDTH-1:0] simple_res_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] fix_lo_s;
    logic [WIDTH-1:0] fix_hi_s;

    // Decode the request; DIV codes become reserved when the divider is disabled.
    always_comb begin
        is_mul_s    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_s    = (DIV_ENABLE != 0) && ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
        is_signed_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        b_zero_s    = (bus.b == {WIDTH{1'b0}});
        if (state_r == ST_IDLE && bus.start) begin
            launch_s = is_mul_s || (is_div_s && !b_zero_s);
            single_s = !(is_mul_s || (is_div_s && !b_zero_s));
        end else begin
            launch_s = 1'b0;
            single_s = 1'b0;
        end
    end

    // Single-cycle op results; reserved codes fall through to zero.
    always_comb begin
        simple_res_s = {WIDTH{1'b0}};
        case (bus.op)
            OP_AND:  simple_res_s = bus.a & bus.b;
            OP_OR:   simple_res_s = bus.a | bus.b;
            OP_ADD:  simple_res_s = bus.a + bus.b;
            OP_ANDN: simple_res_s = bus.a & ~bus.b;
            OP_ORN:  simple_res_s = bus.a | ~bus.b;
            OP_SUB:  simple_res_s = bus.a - bus.b;
            OP_SLT:  simple_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: simple_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: simple_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration: shift-add multiply step or restoring-divide step.
    always_comb begin
        add_s = {1'b0, acc_r} + {1'b0, opb_r};
        sub_s = {acc_r, q_r[WIDTH-1]} - {1'b0, opb_r};
        if (mode_div_r) begin
            if (!sub_s[WIDTH]) begin
                acc_step_s = sub_s[WIDTH-1:0];
                q_step_s   = {q_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {acc_r[WIDTH-2:0], q_r[WIDTH-1]};
                q_step_s   = {q_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q_r[0]) begin
                {acc_step_s, q_step_s} = {add_s, q_r[WIDTH-1:1]};
            end else begin
                {acc_step_s, q_step_s} = {1'b0, acc_r, q_r[WIDTH-1:1]};
            end
        end
    end

    // Sign correction applied during FIX.
    always_comb begin
        prod_s   = {acc_r, q_r};
        fix_lo_s = q_r;
        fix_hi_s = acc_r;
        if (mode_div_r) begin
            if (neg_q_r) begin
                fix_lo_s = negate(q_r);
            end else begin
                fix_lo_s = q_r;
            end
            if (neg_r_r) begin
                fix_hi_s = negate(acc_r);
            end else begin
                fix_hi_s = acc_r;
            end
        end else begin
            if (neg_q_r) begin
                prod_s = ~{acc_r, q_r} + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
                prod_s = {acc_r, q_r};
            end
            fix_lo_s = prod_s[WIDTH-1:0];
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iterative datapath: load magnitudes on launch, step while in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            mode_div_r <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        cnt_r      <= {CW{1'b0}};
                        acc_r      <= {WIDTH{1'b0}};
                        q_r        <= magnitude(bus.a, is_signed_s);
                        opb_r      <= magnitude(bus.b, is_signed_s);
                        mode_div_r <= is_div_s;
                        neg_q_r    <= is_signed_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r_r    <= is_signed_s && is_div_s && bus.a[WIDTH-1];
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered outputs: update only on completion, valid pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            busy_r  <= (state_s != ST_IDLE);
            valid_r <= 1'b0;
            if (state_r == ST_FIX) begin
                valid_r  <= 1'b1;
                result_r <= fix_lo_s;
                hi_r     <= fix_hi_s;
                zero_r   <= (fix_lo_s == {WIDTH{1'b0}});
                dbz_r    <= 1'b0;
            end else if (single_s) begin
                valid_r <= 1'b1;
                if (is_div_s && b_zero_s) begin
                    result_r <= {WIDTH{1'b1}};
                    hi_r     <= bus.a;
                    zero_r   <= 1'b0;
                    dbz_r    <= 1'b1;
                end else begin
                    result_r <= simple_res_s;
                    hi_r     <= {WIDTH{1'b0}};
                    zero_r   <= (simple_res_s == {WIDTH{1'b0}});
                    dbz_r    <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.valid       = valid_r;
    assign bus.result      = result_r;
    assign bus.hi          = hi_r;
    assign bus.zero        = zero_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): table of ops with hand-computed
// results, plus sequences for ignored start while busy and mid-op reset.
module tb_seq_alu;
    localparam int W = 32;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        dbz;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    vec_t vq[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W), .DIV_ENABLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [31:0] res,
                           input logic [31:0] hi, input logic zero, input logic dbz);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.lat = lat;
        v.res = res; v.hi = hi; v.zero = zero; v.dbz = dbz;
        vq.push_back(v);
    endtask

    // Issue one op in the current cycle and wait (bounded) for its valid.
    task automatic run_op(input vec_t v);
        int   lat;
        logic busy_ok;
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (bus.valid !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
        if (v.lat > 1) chk({v.name, " busy_held"}, {31'd0, busy_ok}, 32'd1);
        chk({v.name, " busy_at_valid"}, {31'd0, bus.busy}, 32'd0);
        chk({v.name, " result"}, bus.result, v.res);
        chk({v.name, " hi"}, bus.hi, v.hi);
        chk({v.name, " zero"}, {31'd0, bus.zero}, {31'd0, v.zero});
        chk({v.name, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, v.dbz});
    endtask

    initial begin
        int   lat;
        logic stray;
        vec_t v;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 4'd0; bus.a = 32'd0; bus.b = 32'd0;

        add_vec("slt",       4'b0111, 32'd84,        32'd85,        1,  32'd1,         32'd0,         1'b0, 1'b0);
        add_vec("sub_eq",    4'b0110, 32'd5,         32'd5,         1,  32'd0,         32'd0,         1'b1, 1'b0);
        add_vec("add_wrap",  4'b0010, 32'hFFFFFFFF,  32'd1,         1,  32'd0,         32'd0,         1'b1, 1'b0);
        add_vec("and",       4'b0000, 32'hF0F01234,  32'h0FF0FF00,  1,  32'h00F01200,  32'd0,         1'b0, 1'b0);
        add_vec("or",        4'b0001, 32'hA0000000,  32'h00000005,  1,  32'hA0000005,  32'd0,         1'b0, 1'b0);
        add_vec("andn",      4'b0100, 32'h000000FF,  32'h0000000F,  1,  32'h000000F0,  32'd0,         1'b0, 1'b0);
        add_vec("orn",       4'b0101, 32'd0,         32'hFFFFFFF0,  1,  32'h0000000F,  32'd0,         1'b0, 1'b0);
        add_vec("slt_neg",   4'b0111, 32'hFFFFFFFF,  32'd1,         1,  32'd1,         32'd0,         1'b0, 1'b0);
        add_vec("sltu",      4'b1100, 32'hFFFFFFFF,  32'd1,         1,  32'd0,         32'd0,         1'b1, 1'b0);
        add_vec("sub_neg",   4'b0110, 32'd3,         32'd5,         1,  32'hFFFFFFFE,  32'd0,         1'b0, 1'b0);
        add_vec("multu_max", 4'b1001, 32'hFFFFFFFF,  32'd2,         34, 32'hFFFFFFFE,  32'd1,         1'b0, 1'b0);
        add_vec("reserved",  4'b0011, 32'd5,         32'd6,         1,  32'd0,         32'd0,         1'b1, 1'b0);
        add_vec("mult_neg",  4'b1000, 32'hFFFFFFFD,  32'd5,         34, 32'hFFFFFFF1,  32'hFFFFFFFF,  1'b0, 1'b0);
        add_vec("div_neg",   4'b1010, 32'hFFFFFFF9,  32'd2,         34, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0);
        add_vec("divu_zero", 4'b1011, 32'd9,         32'd0,         1,  32'hFFFFFFFF,  32'd9,         1'b0, 1'b1);
        add_vec("divu",      4'b1011, 32'd100,       32'd7,         34, 32'd14,        32'd2,         1'b0, 1'b0);
        add_vec("div_min",   4'b1010, 32'h80000000,  32'hFFFFFFFF,  34, 32'h80000000,  32'd0,         1'b0, 1'b0);
        add_vec("mult_min",  4'b1000, 32'h80000000,  32'h80000000,  34, 32'd0,         32'h40000000,  1'b1, 1'b0);
        add_vec("div_negb",  4'b1010, 32'd7,         32'hFFFFFFFE,  34, 32'hFFFFFFFD,  32'd1,         1'b0, 1'b0);
        add_vec("multu_0",   4'b1001, 32'd0,         32'd12345,     34, 32'd0,         32'd0,         1'b1, 1'b0);
        add_vec("div_zero",  4'b1010, 32'hFFFFFFF8,  32'd0,         1,  32'hFFFFFFFF,  32'hFFFFFFF8,  1'b0, 1'b1);
        add_vec("and_after", 4'b0000, 32'd6,         32'd3,         1,  32'd2,         32'd0,         1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy",   {31'd0, bus.busy},        32'd0);
        chk("rst valid",  {31'd0, bus.valid},       32'd0);
        chk("rst result", bus.result,               32'd0);
        chk("rst hi",     bus.hi,                   32'd0);
        chk("rst zero",   {31'd0, bus.zero},        32'd0);
        chk("rst dbz",    {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table: ops issued back-to-back, each new start lands in the prior valid cycle
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            run_op(v);
        end
        @(posedge clk); #1;
        chk("valid_pulse", {31'd0, bus.valid}, 32'd0);

        // Start pulsed while busy must be ignored
        bus.start = 1'b1; bus.op = 4'b1000; bus.a = 32'hFFFFFFFD; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.valid !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                bus.start = 1'b1; bus.op = 4'b0010; bus.a = 32'd2; bus.b = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("ign latency", 32'(lat), 32'd34);
        chk("ign result",  bus.result, 32'hFFFFFFF1);
        chk("ign hi",      bus.hi,     32'hFFFFFFFF);
        @(posedge clk); #1;
        chk("ign no_extra_valid", {31'd0, bus.valid}, 32'd0);
        chk("ign idle",           {31'd0, bus.busy},  32'd0);
        chk("ign hold",           bus.result,         32'hFFFFFFF1);

        // Reset at T+10 of a MULT
        bus.start = 1'b1; bus.op = 4'b1000; bus.a = 32'd7; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid busy",   {31'd0, bus.busy},  32'd0);
        chk("mid valid",  {31'd0, bus.valid}, 32'd0);
        chk("mid result", bus.result,         32'd0);
        chk("mid hi",     bus.hi,             32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        chk("mid no_valid", {31'd0, stray}, 32'd0);
        v.name = "post_rst_add"; v.op = 4'b0010; v.a = 32'd2; v.b = 32'd3; v.lat = 1;
        v.res = 32'd5; v.hi = 32'd0; v.zero = 1'b0; v.dbz = 1'b0;
        run_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
